mux_nto1_rr: RTL and testbench
==============================

// Module: mux_nto1_rr
// PURPOSE
//  Registered N:1 channel multiplexer with valid/ready handshake on every port.
//  Two modes: fixed select (sel picks the channel) and round-robin arbitration.
//  Successor to the 4:1 combinational mux. Adds width/channel parametrisation,
//  a 1-cycle output register, backpressure and fair arbitration.
//  Used wherever several sources share one downstream sink.
// PARAMETERS
//  NUM_CH   4   number of input channels, >=2. SEL_W = $clog2(NUM_CH) is a localparam.
//  DATA_W   8   data width per channel, >=1.
// PORTS
//  clk       in   1              rising-edge clock
//  rst_n     in   1              asynchronous, active-low reset
//  in_data   in   NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
//  in_valid  in   NUM_CH         per-channel valid
//  in_ready  out  NUM_CH         per-channel ready; at most one bit high per cycle
//  sel       in   SEL_W          channel select, used in fixed mode
//  mode      in   1              0 = fixed select, 1 = round-robin
//  out_data  out  DATA_W         registered output data
//  out_valid out  1              output register holds a beat
//  out_ready in   1              downstream accepts the beat
//  out_ch    out  SEL_W          index of the channel that sourced out_data
// BEHAVIOUR
//  - Reset (async assert, sync deassert done externally):
//    out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
//    in_ready is combinational and is therefore 0 while out is blocked.
//  - load_en = !out_valid | out_ready. The output register is a 1-deep buffer.
//    It is full-throughput: a new beat loads in the same cycle the old one drains.
//  - Grant, combinational, evaluated every cycle:
//    fixed: grant = sel when sel < NUM_CH and in_valid[sel]; otherwise no grant.
//      An out-of-range sel never grants and never asserts in_ready.
//    rr: grant = first i with in_valid[i], searching from rr_ptr upward.
//      The search wraps NUM_CH-1 -> 0. No valid input means no grant.
//  - in_ready[g] = load_en & grant_valid & (g == grant). Every other bit is 0.
//  - Transfer: when in_valid[g] & in_ready[g], on the next edge:
//    out_data <= channel g data, out_ch <= g, out_valid <= 1.
//  - When load_en & no grant, out_valid <= 0 on the next edge. out_data and out_ch hold.
//  - When !load_en, out_data, out_ch and out_valid all hold. Data stays stable under backpressure.
//  - Latency: input accepted at edge k appears on out_* after edge k, i.e. 1 cycle.
//  - rr_ptr advances only on a transfer made in rr mode:
//    rr_ptr <= (g == NUM_CH-1) ? 0 : g+1. Arithmetic is modulo NUM_CH, not 2^SEL_W.
//  - rr_ptr holds in fixed mode. Switching mode takes effect in the same cycle,
//    and the round-robin state is preserved across switches.
//  - sel and mode may change on any cycle. They affect only the next acceptance;
//    a beat already in out_* is unaffected.
//  - Reset mid-operation: a pending out_valid beat is dropped and rr_ptr returns to 0.
//    The upstream source must retry, because in_ready was 0 during reset.
// TESTING
//  1 fixed, NUM_CH=4, DATA_W=1, data={D=1,C=0,B=1,A=0}, all valid, out_ready=1.
//    Drive sel 0,1,2,3 on successive cycles
//    -> out_data 0,1,0,1 with out_ch 0..3, each 1 cycle after sel.
//  2 fixed, sel=2, out_ready=0 for 3 cycles -> out_valid stays 1 and out_data holds.
//    in_ready=0000 during the stall. On release, the next beat loads that same cycle.
//  3 rr, all 4 valid, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 (pointer wraps).
//    in_ready one-hot follows the same order.
//  4 rr, only ch1 and ch3 valid -> out_ch alternates 1,3,1,3. Idle channels are skipped.
//  5 NUM_CH=3, fixed, sel=3 -> no grant, in_ready=000, out_valid falls to 0.
//    In rr mode, rr_ptr wraps 2 -> 0, never 3.
//  6 rst_n low mid-stream with out_valid=1 -> out_valid, out_data, out_ch and rr_ptr = 0
//    immediately (async). After release, rr arbitration restarts at ch0.

Source files
------------

// File: rtl/mux_nto1_rr.sv
// Registered N:1 valid/ready channel multiplexer with fixed-select and
// round-robin modes, a 1-deep full-throughput output register.
//   clk, rst_n            : clock, async active-low reset
//   in_data/in_valid      : NUM_CH packed channels, ch i at [i*DATA_W +: DATA_W]
//   in_ready              : per-channel ready, at most one bit high
//   sel, mode             : fixed channel select, 0=fixed 1=round-robin
//   out_data/out_valid    : registered beat, out_ready from downstream
//   out_ch                : channel that sourced out_data
module mux_nto1_rr #(
    parameter int  NUM_CH = 4,
    parameter int  DATA_W = 8,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     mode,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEL_W-1:0]         out_ch
);

    logic [DATA_W-1:0] r_data;
    logic              r_vld;
    logic [SEL_W-1:0]  r_ch;
    logic [SEL_W-1:0]  r_ptr;

    logic              w_load_en;
    logic              w_gnt_vld;
    logic [SEL_W-1:0]  w_gnt;
    logic [DATA_W-1:0] w_data;

    assign w_load_en = !r_vld || out_ready;

    // Grant search; rr scans from r_ptr upward, wrapping modulo NUM_CH.
    always_comb begin
        int idx;
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        idx       = 0;
        if (mode) begin
            for (int k = 0; k < NUM_CH; k++) begin
                idx = int'(r_ptr) + k;
                if (idx >= NUM_CH) idx = idx - NUM_CH;
                if (!w_gnt_vld && in_valid[idx]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = SEL_W'(idx);
                end
            end
        end else if (int'(sel) < NUM_CH) begin
            if (in_valid[sel]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = sel;
            end
        end
    end

    always_comb begin
        w_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_gnt == SEL_W'(i)) w_data = in_data[i*DATA_W +: DATA_W];
        end
    end

    // Ready is held low while reset is asserted so no beat is lost.
    always_comb begin
        in_ready = '0;
        if (rst_n && w_load_en && w_gnt_vld) in_ready[w_gnt] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_vld  <= 1'b0;
            r_ch   <= '0;
            r_ptr  <= '0;
        end else if (w_load_en) begin
            if (w_gnt_vld) begin
                r_data <= w_data;
                r_ch   <= w_gnt;
                r_vld  <= 1'b1;
                if (mode) begin
                    r_ptr <= (w_gnt == SEL_W'(NUM_CH-1)) ? '0
                                                          : w_gnt + SEL_W'(1);
                end
            end else begin
                r_vld <= 1'b0;
            end
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_vld;
    assign out_ch    = r_ch;

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Directed self-checking bench for mux_nto1_rr.
// Instance a: NUM_CH=4 DATA_W=8; instance b: NUM_CH=3 DATA_W=1.
module tb_mux_nto1_rr;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] a_in_data;
    logic [3:0]  a_in_valid, a_in_ready;
    logic [1:0]  a_sel, a_out_ch;
    logic        a_mode, a_out_valid, a_out_ready;
    logic [7:0]  a_out_data;

    logic [2:0]  b_in_data, b_in_valid, b_in_ready;
    logic [1:0]  b_sel, b_out_ch;
    logic        b_mode, b_out_valid, b_out_ready;
    logic [0:0]  b_out_data;

    int checks = 0;
    int failures = 0;

    mux_nto1_rr #(.NUM_CH(4), .DATA_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .sel(a_sel), .mode(a_mode),
        .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_ch(a_out_ch)
    );

    mux_nto1_rr #(.NUM_CH(3), .DATA_W(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .sel(b_sel), .mode(b_mode),
        .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_ch(b_out_ch)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check ready now, take one edge, check the registered beat.
    task automatic a_beat(input string tag, input logic [3:0] rdy,
                          input logic [1:0] ch, input logic [7:0] d);
        #1;
        chk({tag, "_rdy"}, a_in_ready, rdy);
        tick();
        chk({tag, "_vld"}, a_out_valid, 1'b1);
        chk({tag, "_ch"}, a_out_ch, ch);
        chk({tag, "_dat"}, a_out_data, d);
    endtask

    task automatic b_beat(input string tag, input logic [2:0] rdy,
                          input logic [1:0] ch, input logic d);
        #1;
        chk({tag, "_rdy"}, b_in_ready, rdy);
        tick();
        chk({tag, "_vld"}, b_out_valid, 1'b1);
        chk({tag, "_ch"}, b_out_ch, ch);
        chk({tag, "_dat"}, b_out_data, d);
    endtask

    initial begin
        a_in_data   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        a_in_valid  = 4'b0000;
        a_sel       = 2'd0;
        a_mode      = 1'b0;
        a_out_ready = 1'b1;
        b_in_data   = 3'b101;
        b_in_valid  = 3'b000;
        b_sel       = 2'd0;
        b_mode      = 1'b0;
        b_out_ready = 1'b1;

        // Reset state
        #1;
        chk("rst_vld", a_out_valid, 1'b0);
        chk("rst_dat", a_out_data, 8'h00);
        chk("rst_ch", a_out_ch, 2'd0);
        chk("rst_rdy", a_in_ready, 4'b0000);
        tick();
        tick();
        rst_n = 1'b1;

        // Fixed select sweep
        a_in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            a_sel = 2'(i);
            a_beat("fix", 4'b0001 << i, 2'(i), 8'hA0 + 8'(i) * 8'h11);
        end

        // Backpressure: beat D3 must hold, no ready
        a_sel = 2'd2;
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_rdy", a_in_ready, 4'b0000);
            tick();
            chk("stall_vld", a_out_valid, 1'b1);
            chk("stall_dat", a_out_data, 8'hD3);
            chk("stall_ch", a_out_ch, 2'd3);
        end
        a_out_ready = 1'b1;
        a_beat("release", 4'b0100, 2'd2, 8'hC2);

        // Round robin, all valid, pointer starts at 0
        a_mode = 1'b1;
        for (int k = 0; k < 6; k++) begin
            a_beat("rr_all", 4'b0001 << (k % 4), 2'(k % 4),
                   8'hA0 + 8'(k % 4) * 8'h11);
        end

        // Only ch1 and ch3 valid; pointer is 2 here
        a_in_valid = 4'b1010;
        a_beat("rr_sk0", 4'b1000, 2'd3, 8'hD3);
        a_beat("rr_sk1", 4'b0010, 2'd1, 8'hB1);
        a_beat("rr_sk2", 4'b1000, 2'd3, 8'hD3);
        a_beat("rr_sk3", 4'b0010, 2'd1, 8'hB1);

        // Fixed transfer leaves rr pointer at 2
        a_in_valid = 4'b1111;
        a_mode = 1'b0;
        a_sel = 2'd0;
        a_beat("sw_fix", 4'b0001, 2'd0, 8'hA0);
        a_mode = 1'b1;
        a_beat("sw_rr", 4'b0100, 2'd2, 8'hC2);

        // No valid input: out_valid drops, data and ch hold
        a_in_valid = 4'b0000;
        #1;
        chk("idle_rdy", a_in_ready, 4'b0000);
        tick();
        chk("idle_vld", a_out_valid, 1'b0);
        chk("idle_dat", a_out_data, 8'hC2);
        chk("idle_ch", a_out_ch, 2'd2);

        // Pointer is 3; load a beat then reset mid-stream
        a_in_valid = 4'b1111;
        a_beat("pre_rst", 4'b1000, 2'd3, 8'hD3);
        rst_n = 1'b0;
        #1;
        chk("arst_vld", a_out_valid, 1'b0);
        chk("arst_dat", a_out_data, 8'h00);
        chk("arst_ch", a_out_ch, 2'd0);
        chk("arst_rdy", a_in_ready, 4'b0000);
        tick();
        rst_n = 1'b1;
        a_beat("post_rst0", 4'b0001, 2'd0, 8'hA0);
        a_beat("post_rst1", 4'b0010, 2'd1, 8'hB1);
        a_in_valid = 4'b0000;

        // Three channels: out-of-range select never grants
        b_in_valid = 3'b111;
        b_sel = 2'd0;
        b_beat("b_fix0", 3'b001, 2'd0, 1'b1);
        b_sel = 2'd3;
        #1;
        chk("b_sel3_rdy", b_in_ready, 3'b000);
        tick();
        chk("b_sel3_vld", b_out_valid, 1'b0);
        chk("b_sel3_dat", b_out_data, 1'b1);
        chk("b_sel3_ch", b_out_ch, 2'd0);

        // Three channels round robin wraps 2 -> 0
        b_mode = 1'b1;
        b_beat("b_rr0", 3'b001, 2'd0, 1'b1);
        b_beat("b_rr1", 3'b010, 2'd1, 1'b0);
        b_beat("b_rr2", 3'b100, 2'd2, 1'b1);
        b_beat("b_rr3", 3'b001, 2'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
